// File: rtl/clken_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clken_divider_pkg
// Brief   : Shared types and helpers for the clock-enable divider.
//           Provides the lock FSM state type, the lock counter width and
//           the channel-index width helper.
// Rev     : 1.0  initial release
// ============================================================================
package clken_divider_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    // Wide enough for the largest settle count (65535)
    localparam int LOCK_CNT_W = 16;

    // Channel index width: clog2 of the channel count, never less than 1
    function automatic int unsigned ch_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clken_ch_counter.sv
`default_nettype none
// ============================================================================
// Module  : clken_ch_counter
// Brief   : One clock-enable channel: divide-ratio register, phase counter
//           and registered one-cycle enable pulse. A synchronous clear holds
//           the channel idle so that all channels restart in phase.
// Rev     : 1.0  initial release
// ============================================================================
module clken_ch_counter #(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 2
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_wr_en,
    input  logic [DIV_W-1:0] i_wr_div,
    output logic             o_clken
);

    logic [DIV_W-1:0] r_div_q;
    logic [DIV_W-1:0] w_div_d;
    logic [DIV_W-1:0] w_div_last;
    logic [DIV_W-1:0] r_cnt_q;
    logic [DIV_W-1:0] w_cnt_d;
    logic             r_clken_q;
    logic             w_clken_d;

    // Ratio update and terminal count; ratios 0 and 1 both mean "every cycle"
    always_comb begin
        w_div_d    = i_wr_en ? i_wr_div : r_div_q;
        w_div_last = (r_div_q <= DIV_W'(1)) ? '0 : (r_div_q - DIV_W'(1));
    end

    // Phase counter: pulse at count 0, count up to div-1 and wrap to 0
    always_comb begin
        w_cnt_d   = '0;
        w_clken_d = 1'b0;
        if (!i_clr) begin
            w_clken_d = (r_cnt_q == '0);
            w_cnt_d   = (r_cnt_q >= w_div_last) ? '0 : (r_cnt_q + DIV_W'(1));
        end
    end

    // Channel state registers
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_div_q   <= DIV_W'(DIV_DEFAULT);
            r_cnt_q   <= '0;
            r_clken_q <= 1'b0;
        end else begin
            r_div_q   <= w_div_d;
            r_cnt_q   <= w_cnt_d;
            r_clken_q <= w_clken_d;
        end
    end

    assign o_clken = r_clken_q;

endmodule
`default_nettype wire

// File: rtl/clken_divider.sv
`default_nettype none
// ============================================================================
// Module  : clken_divider
// Brief   : Multi-channel clock-enable generator with a lock FSM. Divide
//           ratios are reprogrammed through a valid/ready port; every change
//           forces a relock so all channels restart phase-aligned.
//           Optional macro CLKEN_DIVIDER_ERR_EN adds a sticky cfg_err output
//           flagging accepted requests that addressed a missing channel.
// Rev     : 1.0  initial release
// ============================================================================
module clken_divider
    import clken_divider_pkg::*;
#(
    parameter int unsigned NUM_CH      = 3,
    parameter int          DIV_W       = 8,
    parameter int          DIV_DEFAULT = 2,
    parameter int          LOCK_CYCLES = 16
) (
    input  logic                        refclk,
    input  logic                        rst,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [ch_w(NUM_CH)-1:0]     cfg_ch,
    input  logic [DIV_W-1:0]            cfg_div,
    output logic [NUM_CH-1:0]           clken,
    output logic                        locked
`ifdef CLKEN_DIVIDER_ERR_EN
    ,
    output logic                        cfg_err
`endif
);

    state_e                r_state_q;
    state_e                w_state_d;
    logic [LOCK_CNT_W-1:0] r_lock_cnt_q;
    logic [LOCK_CNT_W-1:0] w_lock_cnt_d;
    logic                  r_locked_q;
    logic                  w_locked_d;
    logic                  r_cfg_ready_q;
    logic                  w_accept;
    logic                  w_clr;
    logic [NUM_CH-1:0]     w_wr_en;

    assign w_accept = cfg_valid && r_cfg_ready_q;

    // Lock sequencing: leave HOLD, settle LOCK_CYCLES edges, relock on any write
    always_comb begin
        w_state_d    = r_state_q;
        w_lock_cnt_d = r_lock_cnt_q;
        case (r_state_q)
            HOLD: begin
                w_state_d    = LOCKING;
                w_lock_cnt_d = '0;
            end
            LOCKING: begin
                if (r_lock_cnt_q == LOCK_CNT_W'(LOCK_CYCLES - 1)) begin
                    w_state_d    = LOCKED;
                    w_lock_cnt_d = '0;
                end else begin
                    w_lock_cnt_d = r_lock_cnt_q + LOCK_CNT_W'(1);
                end
            end
            LOCKED: begin
                if (w_accept) begin
                    w_state_d    = LOCKING;
                    w_lock_cnt_d = '0;
                end
            end
            default: begin
                w_state_d    = HOLD;
                w_lock_cnt_d = '0;
            end
        endcase
        w_locked_d = (w_state_d == LOCKED);
    end

    // Channels are held cleared whenever the next cycle is not locked, so the
    // first pulse of every channel lands on the first locked cycle
    assign w_clr = !w_locked_d;

    // FSM state and registered status outputs
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state_q     <= HOLD;
            r_lock_cnt_q  <= '0;
            r_locked_q    <= 1'b0;
            r_cfg_ready_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_lock_cnt_q  <= w_lock_cnt_d;
            r_locked_q    <= w_locked_d;
            r_cfg_ready_q <= w_locked_d;
        end
    end

    assign locked    = r_locked_q;
    assign cfg_ready = r_cfg_ready_q;

`ifdef CLKEN_DIVIDER_ERR_EN
    logic w_ch_oob;
    logic r_err_q;

    assign w_ch_oob = (32'(cfg_ch) >= NUM_CH);

    // Sticky flag for accepted requests aimed at a channel that does not exist
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_err_q <= 1'b0;
        end else if (w_accept && w_ch_oob) begin
            r_err_q <= 1'b1;
        end
    end

    assign cfg_err = r_err_q;
`endif

    // One counter per channel; out-of-range indices match no channel
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_wr_en[i] = w_accept && (32'(cfg_ch) == i);

        clken_ch_counter #(
            .DIV_W       (DIV_W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_ch (
            .refclk   (refclk),
            .rst      (rst),
            .i_clr    (w_clr),
            .i_wr_en  (w_wr_en[i]),
            .i_wr_div (cfg_div),
            .o_clken  (clken[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clken_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_clken_divider
// Brief   : Self-checking bench for clken_divider. A time-based reference
//           model predicts locked/cfg_ready/clken every cycle; a vector table
//           drives reconfigurations and checks relock delay and periods.
//           Builds with or without CLKEN_DIVIDER_ERR_EN.
// Rev     : 1.0  initial release
// ============================================================================
module tb_clken_divider;

    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 8;
    localparam int DIV_DEFAULT = 2;
    localparam int LOCK_CYCLES = 16;

    logic             refclk    = 1'b0;
    logic             rst       = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [1:0]       cfg_ch    = '0;
    logic [DIV_W-1:0] cfg_div   = '0;
    logic             cfg_ready;
    logic [NUM_CH-1:0] clken;
    logic             locked;
`ifdef CLKEN_DIVIDER_ERR_EN
    logic             cfg_err;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: locked from lock_at onwards; channel i pulses when
    // (cycle - lock_at) is a multiple of its effective ratio
    int m_div [NUM_CH];
    bit m_hold = 1'b1;
    bit m_err  = 1'b0;
    int n       = 0;
    int lock_at = 0;

    typedef struct {
        int ch;
        int div;
        int p0;
        int p1;
        int p2;
    } vec_t;

    vec_t vt [7];

    clken_divider #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEFAULT),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .clken     (clken),
        .locked    (locked)
`ifdef CLKEN_DIVIDER_ERR_EN
        ,
        .cfg_err   (cfg_err)
`endif
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int eff(input int d);
        return (d <= 1) ? 1 : d;
    endfunction

    function automatic bit exp_locked();
        return !m_hold && (n >= lock_at);
    endfunction

    task automatic check_outputs(input string tag);
        int e_clk;
        e_clk = 0;
        for (int i = 0; i < NUM_CH; i++)
            if (exp_locked() && (((n - lock_at) % eff(m_div[i])) == 0))
                e_clk |= (1 << i);
        chk({tag, ".locked"}, int'(locked), int'(exp_locked()));
        chk({tag, ".ready"},  int'(cfg_ready), int'(exp_locked()));
        chk({tag, ".clken"},  int'(clken), e_clk);
`ifdef CLKEN_DIVIDER_ERR_EN
        chk({tag, ".err"},    int'(cfg_err), int'(m_err));
`endif
    endtask

    // One clock edge: update the model from the inputs seen at the edge,
    // then compare outputs 1 time unit later
    task automatic step();
        bit pre_locked;
        @(posedge refclk);
        pre_locked = exp_locked();
        n++;
        if (rst) begin
            m_hold = 1'b1;
        end else if (m_hold) begin
            m_hold  = 1'b0;
            lock_at = n + LOCK_CYCLES;
        end else if (cfg_valid && pre_locked) begin
            if (cfg_ch < NUM_CH) m_div[cfg_ch] = int'(cfg_div);
            else                 m_err = 1'b1;
            lock_at = n + LOCK_CYCLES;
        end
        #1;
        check_outputs("cyc");
    endtask

    task automatic assert_rst();
        rst    = 1'b1;
        m_hold = 1'b1;
        m_err  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) m_div[i] = DIV_DEFAULT;
        #1;
        check_outputs("rst_async");
    endtask

    // Bounded wait for locked; the edge count is itself a comparison
    task automatic wait_locked(input string name, input int exp_edges);
        int k;
        k = 0;
        while (!locked && k < 400) begin
            step();
            k++;
        end
        chk(name, k, exp_edges);
    endtask

    // Called on the first locked cycle: all channels must pulse now, and the
    // next pulse of each channel gives its period
    task automatic measure(input string name, input int p0, input int p1, input int p2);
        int first [NUM_CH];
        int exp_p [NUM_CH];
        exp_p[0] = p0;
        exp_p[1] = p1;
        exp_p[2] = p2;
        chk({name, ".align"}, int'(clken), (1 << NUM_CH) - 1);
        for (int i = 0; i < NUM_CH; i++) first[i] = -1;
        for (int t = 1; t <= 300; t++) begin
            step();
            for (int i = 0; i < NUM_CH; i++)
                if (first[i] < 0 && clken[i]) first[i] = t;
            if (first[0] >= 0 && first[1] >= 0 && first[2] >= 0) break;
        end
        for (int i = 0; i < NUM_CH; i++) chk({name, ".period"}, first[i], exp_p[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // {channel, ratio, expected period ch0, ch1, ch2}
        vt[0] = '{ch: 1, div: 5,   p0: 2, p1: 5, p2: 2};
        vt[1] = '{ch: 0, div: 0,   p0: 1, p1: 5, p2: 2};
        vt[2] = '{ch: 0, div: 1,   p0: 1, p1: 5, p2: 2};
        vt[3] = '{ch: 3, div: 9,   p0: 1, p1: 5, p2: 2};
        vt[4] = '{ch: 2, div: 255, p0: 1, p1: 5, p2: 255};
        vt[5] = '{ch: 2, div: 3,   p0: 1, p1: 5, p2: 3};
        vt[6] = '{ch: 0, div: 2,   p0: 2, p1: 5, p2: 3};
        for (int i = 0; i < NUM_CH; i++) m_div[i] = DIV_DEFAULT;

        // Reset state, then release: one edge leaves HOLD, 16 more in LOCKING
        #2;
        assert_rst();
        step();
        step();
        rst = 1'b0;
        wait_locked("boot.relock", LOCK_CYCLES + 1);
        measure("boot", 2, 2, 2);

        // Table-driven reconfiguration
        for (int v = 0; v < 7; v++) begin
            chk("vec.ready", int'(cfg_ready), 1);
            cfg_valid = 1'b1;
            cfg_ch    = 2'(vt[v].ch);
            cfg_div   = 8'(vt[v].div);
            step();
            cfg_valid = 1'b0;
            chk("vec.drop", int'(locked), 0);
            wait_locked("vec.relock", LOCK_CYCLES);
            measure("vec", vt[v].p0, vt[v].p1, vt[v].p2);
        end

        // Reset 7 cycles into LOCKING discards the written ratio
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_div   = 8'd7;
        step();
        cfg_valid = 1'b0;
        repeat (7) step();
        assert_rst();
        step();
        step();
        rst = 1'b0;
        wait_locked("rst2.relock", LOCK_CYCLES + 1);
        measure("rst2", 2, 2, 2);

        // cfg_valid held through LOCKING: ignored until locked, then accepted
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 8'd4;
        step();
        cfg_div   = 8'd6;
        wait_locked("hold.relock", LOCK_CYCLES);
        step();
        chk("hold.reaccept", int'(locked), 0);
        cfg_valid = 1'b0;
        wait_locked("hold.relock2", LOCK_CYCLES);
        measure("hold", 6, 2, 2);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            cfg_valid = ($urandom_range(0, 9) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       cfg_div = 8'($urandom_range(0, 1));
                1, 2:    cfg_div = 8'($urandom_range(2, 9));
                default: cfg_div = 8'($urandom);
            endcase
            if (rst)                                rst = 1'b0;
            else if ($urandom_range(0, 299) == 0)   assert_rst();
            step();
        end
        cfg_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
